// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core.
// Performs RPC rounds per clock over a rolling 16-word message schedule window,
// then folds the working variables into the chaining value in a final cycle.
module sha256_iter_core #(
    parameter int RPC      = 1,
    parameter int OUT_HOLD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic [0:15][31:0] W,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:7][31:0]  H_out,
    output logic              busy
);

    if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : g_bad_rpc
        $fatal(1, "sha256_iter_core: RPC must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} state_t;

    localparam logic [0:7][31:0] H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [5:0] STEP = 6'(RPC);
    localparam logic [5:0] LAST = 6'(64 - RPC);   // counter value of the final RUN cycle

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // One compression round; s[0..7] = a..h.
    function automatic logic [0:7][31:0] round_f(input logic [0:7][31:0] s,
                                                 input logic [31:0] w, input logic [31:0] k);
        logic [31:0] t1;
        logic [31:0] t2;
        logic [0:7][31:0] r;
        t1 = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
        t2 = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        r[0] = t1 + t2;
        r[1] = s[0];
        r[2] = s[1];
        r[3] = s[2];
        r[4] = s[3] + t1;
        r[5] = s[4];
        r[6] = s[5];
        r[7] = s[6];
        return r;
    endfunction

    state_t            state;
    logic [5:0]        round_cnt;
    logic              first_r;      // block chains from H0 rather than the stored digest
    logic [0:7][31:0]  digest;
    logic [0:15][31:0] win;
    logic [0:15][31:0] win_nxt;
    logic [0:7][31:0]  work;
    logic [0:7][31:0]  work_nxt;
    logic [31:0]       ext [0:15+RPC];
    logic              accept;

    assign accept = in_valid && in_ready;
    assign H_out  = digest;

    // Extend the window by RPC schedule words and run RPC rounds in order.
    always_comb begin
        // NOTE: every element is assigned on every pass before it is read, so no latch can form.
        for (int i = 0; i < 16; i++) ext[i] = win[i];
        for (int j = 0; j < RPC; j++)
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        work_nxt = work;
        for (int j = 0; j < RPC; j++)
            work_nxt = round_f(work_nxt, ext[j], K[round_cnt + 6'(j)]);
        for (int i = 0; i < 16; i++) win_nxt[i] = ext[RPC+i];
    end

    // Control FSM with registered handshake outputs and the stored digest.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignment so every branch sees pre-edge values.
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            round_cnt <= '0;
            first_r   <= 1'b1;
            digest    <= H0;
        end else begin
            case (state)
                S_IDLE: begin
                    out_valid <= 1'b0;
                    if (accept) begin
                        state     <= S_RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        round_cnt <= '0;
                        first_r   <= in_first;
                    end
                end
                S_RUN: begin
                    round_cnt <= round_cnt + STEP;
                    if (round_cnt == LAST) state <= S_FINAL;
                end
                S_FINAL: begin
                    for (int i = 0; i < 8; i++)
                        digest[i] <= (first_r ? H0[i] : digest[i]) + work[i];
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    if (OUT_HOLD != 0) begin
                        state <= S_DONE;
                    end else begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Schedule window and working variables: loaded on accept, advanced in RUN.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are left unreset; they are always loaded on accept before being read.
        if (accept) begin
            win  <= W;
            work <= in_first ? H0 : digest;
        end else if (state == S_RUN) begin
            win  <= win_nxt;
            work <= work_nxt;
        end
    end

endmodule

// File: doc/sha256_iter_core.md
SHA256_ITER_CORE -- requirements
Module: sha256_iter_core

Interface
REQ-001 SHALL have parameter: RPC, 1, SHA-256 rounds per clock; legal values 1, 2, 4, 8, 16; any other value fails elaboration.
REQ-002 SHALL have parameter: OUT_HOLD, 1, 1 = hold result until out_ready; 0 = one-cycle out_valid pulse, out_ready ignored.
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  block offered.
REQ-006 SHALL have port: in_ready  output  1  core can accept a block.
REQ-007 SHALL have port: in_first  input  1  1 = chain from FIPS 180-4 IV H0; 0 = chain from stored digest; sampled with the block.
REQ-008 SHALL have port: W  input  [0:15][31:0]  padded 512-bit block; W[0] is the first big-endian message word.
REQ-009 SHALL have port: out_valid  output  1  H_out holds a finished digest.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts digest (OUT_HOLD=1 only).
REQ-011 SHALL have port: H_out  output  [0:7][31:0]  chaining value after the last accepted block; H_out[0] = digest bits 255:224.
REQ-012 SHALL have port: busy  output  1  high in RUN and FINAL.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> FINAL -> DONE -> IDLE; DONE is skipped when OUT_HOLD=0.
REQ-014 SHALL assert in_ready only in IDLE; a block is accepted on a rising edge with in_valid && in_ready.
REQ-015 SHALL, on accept, latch W into a 16-word schedule window, load a..h from H0 (in_first=1) or the stored digest (in_first=0), clear the round counter, and enter RUN.
REQ-016 SHALL, in RUN, perform exactly RPC rounds per cycle in round order t, t+1, ..., and advance the round counter by RPC.
REQ-017 SHALL generate W[t] for t >= 16 on the fly as sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], shifting the window by RPC words per cycle; no 64-word array SHALL be stored.
REQ-018 SHALL use sigma0 = ROTR7 ^ ROTR18 ^ SHR3 and sigma1 = ROTR17 ^ ROTR19 ^ SHR10; all additions are mod 2^32 with carries discarded.
REQ-019 SHALL take K constants from an internal 64-entry table indexed by the round number.
REQ-020 SHALL leave RUN after the cycle that completes round 63 (counter wrap 64 -> 0) and enter FINAL.
REQ-021 SHALL, in FINAL, add a..h word-wise to the chaining value, update the stored digest and H_out, and go to DONE (OUT_HOLD=1) or IDLE (OUT_HOLD=0).
REQ-022 SHALL give latency 64/RPC + 1 cycles from the accept edge to the first cycle of out_valid.
REQ-023 SHALL, with OUT_HOLD=1, hold out_valid and H_out stable in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-024 SHALL, with OUT_HOLD=0, assert out_valid for exactly one cycle, in the cycle after FINAL.
REQ-025 SHALL ignore in_valid, in_first and W outside IDLE; changes to them mid-block SHALL NOT affect the result.
REQ-026 SHALL keep H_out at the last digest while idle and while the next block is computing; in_first=0 after reset SHALL chain from H0.

Reset
REQ-027 SHALL, while reset is high, force state IDLE, in_ready=1, out_valid=0, busy=0, round counter 0, and stored digest and H_out = H0 (6a09e667 ... 5be0cd19).
REQ-028 SHALL abort any block in flight on reset assertion, with no digest update, and accept a new block on the first edge after reset deassertion.

Verification
REQ-029 SHALL pass this directed test, all RPC values: W[0]=61626380, W[1..14]=0, W[15]=00000018, in_first=1 -> H_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, out_valid on cycle 64/RPC+1 after accept.
REQ-030 SHALL pass this directed test: W[0]=80000000, rest 0, in_first=1 -> H_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-031 SHALL pass this directed test: two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", in_first=1 then 0 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-032 SHALL pass this directed test: OUT_HOLD=1, out_ready held 0 for 10 cycles in DONE -> out_valid and H_out stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-033 SHALL pass this directed test: reset asserted mid-RUN of block 2 of the two-block test, then "abc" with in_first=0 -> "abc" digest (chain restarts from H0).
REQ-034 SHALL pass this directed test: in_valid=1 and W toggled randomly during RUN -> no extra accept, digest unchanged from the REQ-029 value.
